param_updown_counter: RTL and testbench
=======================================

Name: param_updown_counter

Overview:
Next-generation parametrised up/down counter. It generalises the fixed 4-bit counter to WIDTH bits and adds:
- programmable upper limit
- synchronous load with clamping
- synchronous clear and count enable
- three end-of-range modes: wrap, saturate, one-shot
- terminal-count and wrap-event outputs

Used as a general timer/event counter in datapath and control blocks.

Parameters:
WIDTH, 4, counter/limit/load width in bits (>=2).
RESET_VALUE, 0, value of out after reset (must be <= all limits used).

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
enable  input  1  count enable; one step per cycle while high.
clear  input  1  synchronous clear to 0; highest synchronous priority.
load  input  1  synchronous load of initial_value.
initial_value  input  WIDTH  value loaded on load (clamped to limit).
up_and_down  input  1  1 = count up, 0 = count down.
mode  input  2  00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap.
limit  input  WIDTH  upper bound; legal range is 0..limit inclusive.
out  output  WIDTH  registered count value.
terminal  output  1  combinational: (up_and_down && out>=limit) || (!up_and_down && out==0).
wrapped  output  1  registered one-cycle pulse, set in the cycle after a wrap step.
done  output  1  registered, sticky; one-shot mode only.

Behaviour:
- Reset (reset==0, async, no clock needed):
  - out=RESET_VALUE, wrapped=0, done=0, FSM=RUN.
  - Release is synchronous to the next clk edge; no count on the release edge unless enable is high on that edge.
- Per-edge priority: clear > load > enable > hold.
- clear:
  - out=0, wrapped=0, done=0, FSM=RUN.
- load:
  - out = (initial_value > limit) ? limit : initial_value; wrapped=0, done=0, FSM=RUN.
- FSM states: RUN, DONE.
  - RUN->DONE: mode==10 and a count step lands on the terminal value (limit going up, 0 going down), or the step is attempted while already terminal.
  - DONE->RUN: only on clear, load or reset.
  - In DONE: out holds and enable is ignored.
- Count step (enable=1, RUN, no clear/load):
  - Up, out<limit: out+1.
  - Up, out>=limit:
    - wrap: out=0, wrapped=1.
    - saturate: out=limit.
    - one-shot: out=limit, enter DONE.
  - Down, out>0: out-1. Also applies when out>limit, e.g. after limit is lowered.
  - Down, out==0:
    - wrap: out=limit, wrapped=1.
    - saturate: out=0.
    - one-shot: out=0, enter DONE.
- wrapped:
  - High exactly one cycle after each wrap step; 0 on all other cycles.
  - Back-to-back wraps (limit==0, enable held) keep it high continuously.
- done = (FSM==DONE). It rises the cycle the terminal step is registered.
- limit==0: out stays 0 in every mode; wrap mode pulses wrapped every enabled cycle.
- limit or mode changed mid-count: takes effect on the next edge, no pipeline delay.
- Arithmetic is pure WIDTH-bit unsigned. out never exceeds max(limit, value held before limit was lowered).
- Latency: out, wrapped and done are 1 cycle after the controlling inputs; terminal is 0-cycle from out.

Test Plan:
- WIDTH=4, mode=00, limit=9, up, enable held 12 cycles from 0 -> out 1..9,0,1,2; wrapped high only the cycle out shows 0; terminal high while out==9.
- mode=01, limit=15, down, load initial_value=2 then enable 5 cycles -> out 2,1,0,0,0,0; wrapped never asserts; terminal=1 from out==0.
- mode=10, limit=5, up, load 3, enable 6 cycles -> out 4,5 then holds 5; done=1 from the cycle out==5 and stays 1; load 1 -> done=0, out=1.
- limit=7, load initial_value=12 -> out=7. Then limit=3 and count up in wrap mode -> out=0, wrapped pulse. Repeat from out=7 counting down -> out=6.
- Simultaneous clear=1, load=1, enable=1 with out=6 -> out=0, done=0. Load=1 with enable=1 -> loaded value, no step that cycle.
- Assert reset low mid-count between clock edges (out=5, done=1) -> out=RESET_VALUE, wrapped=0, done=0 immediately. Release, enable high, up -> out=1 on the first edge after release.

Source files
------------

// File: rtl/param_updown_counter_if.sv
// Control and status bundle for the parametrised up/down counter.
// master drives the controls, slave is the counter itself.
interface param_updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             enable;
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] initial_value;
    logic             up_and_down;
    logic [1:0]       mode;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] out;
    logic             terminal;
    logic             wrapped;
    logic             done;

    modport master (
        output enable, clear, load, initial_value,
        output up_and_down, mode, limit,
        input  out, terminal, wrapped, done
    );

    modport slave (
        input  enable, clear, load, initial_value,
        input  up_and_down, mode, limit,
        output out, terminal, wrapped, done
    );
endinterface

// File: rtl/param_updown_counter.sv
// WIDTH-bit up/down counter with programmable limit,
// clamped load and wrap / saturate / one-shot end modes.
module param_updown_counter #(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input logic                   clk,
    input logic                   reset,
    param_updown_counter_if.slave bus
);
    typedef enum logic {
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] inc;
    logic [WIDTH-1:0] dec;
    logic             at_top;
    logic             at_bot;
    logic             sat;
    logic             one_shot;

    // Mode 11 falls through to wrap behaviour.
    assign sat      = (bus.mode == 2'b01);
    assign one_shot = (bus.mode == 2'b10);
    assign load_val = (bus.initial_value > bus.limit) ?
                      bus.limit : bus.initial_value;
    assign inc      = bus.out + 1'b1;
    assign dec      = bus.out - 1'b1;
    assign at_top   = (bus.out >= bus.limit);
    assign at_bot   = (bus.out == '0);

    // Terminal follows out directly, no register.
    assign bus.terminal = (bus.up_and_down && at_top) ||
                          (!bus.up_and_down && at_bot);

    // Count register, wrap pulse and RUN/DONE state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.out     <= RESET_VALUE;
            bus.wrapped <= 1'b0;
            bus.done    <= 1'b0;
            state       <= RUN;
        end else if (bus.clear) begin
            bus.out     <= '0;
            bus.wrapped <= 1'b0;
            bus.done    <= 1'b0;
            state       <= RUN;
        end else if (bus.load) begin
            bus.out     <= load_val;
            bus.wrapped <= 1'b0;
            bus.done    <= 1'b0;
            state       <= RUN;
        end else begin
            bus.wrapped <= 1'b0;
            if (bus.enable && state == RUN) begin
                if (bus.up_and_down) begin
                    if (!at_top) begin
                        bus.out <= inc;
                        if (one_shot && inc == bus.limit) begin
                            bus.done <= 1'b1;
                            state    <= DONE;
                        end
                    end else begin
                        unique case (1'b1)
                            sat: begin
                                bus.out <= bus.limit;
                            end
                            one_shot: begin
                                bus.out  <= bus.limit;
                                bus.done <= 1'b1;
                                state    <= DONE;
                            end
                            default: begin
                                bus.out     <= '0;
                                bus.wrapped <= 1'b1;
                            end
                        endcase
                    end
                end else begin
                    if (!at_bot) begin
                        bus.out <= dec;
                        if (one_shot && dec == '0) begin
                            bus.done <= 1'b1;
                            state    <= DONE;
                        end
                    end else begin
                        unique case (1'b1)
                            sat: begin
                                bus.out <= '0;
                            end
                            one_shot: begin
                                bus.out  <= '0;
                                bus.done <= 1'b1;
                                state    <= DONE;
                            end
                            default: begin
                                bus.out     <= bus.limit;
                                bus.wrapped <= 1'b1;
                            end
                        endcase
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_param_updown_counter.sv
// Directed vector bench for param_updown_counter,
// WIDTH=4, RESET_VALUE=0.
module tb_param_updown_counter;
    localparam int W = 4;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    param_updown_counter_if #(.WIDTH(W)) bus ();

    param_updown_counter #(
        .WIDTH(W),
        .RESET_VALUE(4'd0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    typedef struct {
        logic         clr;
        logic         ld;
        logic         en;
        logic         up;
        logic [1:0]   md;
        logic [W-1:0] lim;
        logic [W-1:0] init;
        logic [W-1:0] e_out;
        logic         e_term;
        logic         e_wr;
        logic         e_done;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    function automatic vec_t v(
        input logic clr, input logic ld, input logic en,
        input logic up, input logic [1:0] md,
        input logic [W-1:0] lim, input logic [W-1:0] init,
        input logic [W-1:0] e_out, input logic e_term,
        input logic e_wr, input logic e_done
    );
        vec_t r;
        r.clr = clr; r.ld = ld; r.en = en; r.up = up;
        r.md = md; r.lim = lim; r.init = init;
        r.e_out = e_out; r.e_term = e_term;
        r.e_wr = e_wr; r.e_done = e_done;
        return r;
    endfunction

    task automatic check(input string name,
                         input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d",
                     name, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input int o,
                             input int t, input int w,
                             input int d);
        check({tag, ".out"}, int'(bus.out), o);
        check({tag, ".terminal"}, int'(bus.terminal), t);
        check({tag, ".wrapped"}, int'(bus.wrapped), w);
        check({tag, ".done"}, int'(bus.done), d);
    endtask

    task automatic drive(input logic clr, input logic ld,
                         input logic en, input logic up,
                         input logic [1:0] md,
                         input logic [W-1:0] lim,
                         input logic [W-1:0] init);
        bus.clear         = clr;
        bus.load          = ld;
        bus.enable        = en;
        bus.up_and_down   = up;
        bus.mode          = md;
        bus.limit         = lim;
        bus.initial_value = init;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clk      = 1'b0;
        reset    = 1'b0;
        drive(0, 0, 0, 1, 2'b00, 4'd9, 4'd0);

        // wrap, limit 9, count up 12 cycles
        vecs.push_back(v(1,0,0,1,0,9,0, 0,0,0,0));
        for (int k = 1; k <= 8; k++)
            vecs.push_back(v(0,0,1,1,0,9,0, k[W-1:0],0,0,0));
        vecs.push_back(v(0,0,1,1,0,9,0, 9,1,0,0));
        vecs.push_back(v(0,0,1,1,0,9,0, 0,0,1,0));
        vecs.push_back(v(0,0,1,1,0,9,0, 1,0,0,0));
        vecs.push_back(v(0,0,1,1,0,9,0, 2,0,0,0));
        // saturate down from 2
        vecs.push_back(v(0,1,0,0,1,15,2, 2,0,0,0));
        vecs.push_back(v(0,0,1,0,1,15,0, 1,0,0,0));
        vecs.push_back(v(0,0,1,0,1,15,0, 0,1,0,0));
        vecs.push_back(v(0,0,1,0,1,15,0, 0,1,0,0));
        vecs.push_back(v(0,0,1,0,1,15,0, 0,1,0,0));
        vecs.push_back(v(0,0,1,0,1,15,0, 0,1,0,0));
        // one-shot up to 5 then sticky
        vecs.push_back(v(0,1,0,1,2,5,3, 3,0,0,0));
        vecs.push_back(v(0,0,1,1,2,5,0, 4,0,0,0));
        vecs.push_back(v(0,0,1,1,2,5,0, 5,1,0,1));
        vecs.push_back(v(0,0,1,1,2,5,0, 5,1,0,1));
        vecs.push_back(v(0,0,1,1,2,5,0, 5,1,0,1));
        vecs.push_back(v(0,0,1,1,2,5,0, 5,1,0,1));
        vecs.push_back(v(0,0,1,1,2,5,0, 5,1,0,1));
        vecs.push_back(v(0,1,0,1,2,5,1, 1,0,0,0));
        // clamped load, then limit lowered
        vecs.push_back(v(0,1,0,1,0,7,12, 7,1,0,0));
        vecs.push_back(v(0,0,1,1,0,3,0, 0,0,1,0));
        vecs.push_back(v(0,1,0,0,0,7,12, 7,0,0,0));
        vecs.push_back(v(0,0,1,0,0,3,0, 6,0,0,0));
        // priority: clear over load over enable
        vecs.push_back(v(1,1,1,0,0,3,5, 0,1,0,0));
        vecs.push_back(v(0,1,1,1,0,9,4, 4,0,0,0));
        // limit 0 in wrap mode: back-to-back wraps
        vecs.push_back(v(0,0,1,1,0,0,0, 0,1,1,0));
        vecs.push_back(v(0,0,1,1,0,0,0, 0,1,1,0));
        vecs.push_back(v(0,0,1,1,0,0,0, 0,1,1,0));
        vecs.push_back(v(0,0,0,1,0,0,0, 0,1,0,0));
        vecs.push_back(v(0,0,1,0,1,0,0, 0,1,0,0));
        // mode 11 behaves as wrap
        vecs.push_back(v(0,1,0,1,3,2,2, 2,1,0,0));
        vecs.push_back(v(0,0,1,1,3,2,0, 0,0,1,0));
        // one-shot down, clear releases DONE
        vecs.push_back(v(0,1,0,0,2,9,1, 1,0,0,0));
        vecs.push_back(v(0,0,1,0,2,9,0, 0,1,0,1));
        vecs.push_back(v(0,0,1,0,2,9,0, 0,1,0,1));
        vecs.push_back(v(1,0,1,0,2,9,0, 0,1,0,0));
        // step attempted while already terminal
        vecs.push_back(v(0,0,1,0,2,9,0, 0,1,0,1));
        vecs.push_back(v(1,0,0,0,0,9,0, 0,1,0,0));

        #12;
        check_all("reset", 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].clr, vecs[i].ld, vecs[i].en,
                  vecs[i].up, vecs[i].md, vecs[i].lim,
                  vecs[i].init);
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i),
                      int'(vecs[i].e_out), int'(vecs[i].e_term),
                      int'(vecs[i].e_wr), int'(vecs[i].e_done));
        end

        // reach out=5 done=1, then async reset between edges
        @(negedge clk);
        drive(0, 1, 0, 1, 2'b10, 4'd5, 4'd4);
        @(negedge clk);
        drive(0, 0, 1, 1, 2'b10, 4'd5, 4'd0);
        @(posedge clk);
        #1;
        check_all("os_pre", 5, 1, 0, 1);
        @(negedge clk);
        drive(0, 0, 0, 1, 2'b00, 4'd9, 4'd0);
        #2;
        reset = 1'b0;
        #1;
        check_all("async_rst", 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        bus.enable = 1'b1;
        @(posedge clk);
        #1;
        check_all("release", 1, 0, 0, 0);

        // wrapped pulse is cleared by async reset too
        @(negedge clk);
        drive(0, 0, 1, 1, 2'b00, 4'd0, 4'd0);
        @(posedge clk);
        #1;
        check_all("wrap_pre", 0, 1, 1, 0);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_wrap.wrapped", int'(bus.wrapped), 0);
        @(negedge clk);
        reset = 1'b1;
        bus.enable = 1'b0;
        @(posedge clk);
        #1;
        check("hold_after_release.out", int'(bus.out), 0);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end
endmodule
